fpu_cmd_seq: RTL and testbench

//  Upstream command sequencer for the fpu top level. Accepts queued commands (host

---
 rtl/fpu_cmd_seq_if.sv | 52 +++++
 rtl/fpu_cmd_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_fpu_cmd_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_cmd_seq_if.sv
// fpu_cmd_seq_if: command, fpu pin, result and status signals of the fpu command sequencer.
// Latency: none; this is a plain bundle of wires.
// Backpressure: cmd_valid/cmd_ready on the command side, res_valid/res_ready on the result side.
interface fpu_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rm;
  logic [4:0]  cmd_a1;
  logic [4:0]  cmd_a2;
  logic [4:0]  cmd_a3;
  logic [31:0] cmd_data;

  logic [4:0]  fpu_addr1;
  logic [4:0]  fpu_addr2;
  logic [4:0]  fpu_addr3;
  logic [2:0]  fpu_opcode;
  logic [2:0]  fpu_round;
  logic        fpu_enable;
  logic        fpu_ld;
  logic        fpu_act;
  logic [31:0] fpu_inp;
  logic [31:0] fpu_out;
  logic        fpu_done;
  logic [7:0]  fpu_flags;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [8:0]  res_flags;
  logic        busy;
  logic [15:0] perf_ops;
  logic [15:0] perf_tmo;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_rm, cmd_a1, cmd_a2, cmd_a3, cmd_data,
    input  fpu_out, fpu_done, fpu_flags, res_ready,
    output cmd_ready, fpu_addr1, fpu_addr2, fpu_addr3, fpu_opcode, fpu_round,
    output fpu_enable, fpu_ld, fpu_act, fpu_inp,
    output res_valid, res_data, res_flags, busy, perf_ops, perf_tmo
  );

  // Host / fpu side.
  modport master (
    output cmd_valid, cmd_op, cmd_rm, cmd_a1, cmd_a2, cmd_a3, cmd_data,
    output fpu_out, fpu_done, fpu_flags, res_ready,
    input  cmd_ready, fpu_addr1, fpu_addr2, fpu_addr3, fpu_opcode, fpu_round,
    input  fpu_enable, fpu_ld, fpu_act, fpu_inp,
    input  res_valid, res_data, res_flags, busy, perf_ops, perf_tmo
  );
endinterface

// File: rtl/fpu_cmd_seq.sv
// fpu_cmd_seq: queues host writes / FP ops and walks the fpu pins through CLR, RD, LD, EXEC, WB.
// Latency: cmd accept to res_valid is 5+n cycles (n = EXEC cycles incl. done) with empty FIFO.
// Backpressure: cmd_ready low when FIFO full (unless popping); res_ready low holds the FSM in WB.
// Option: define FPU_SEQ_PERF_EN for saturating perf_ops/perf_tmo counters (tied 0 otherwise).
module fpu_cmd_seq #(
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 15,
  parameter int SCR_ADDR = 31
) (
  input  logic          clk,
  input  logic          rstp,
  fpu_cmd_seq_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  rm;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] data;
  } cmd_t;

  // Fields still needed once the command has left the FIFO.
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rm;
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] a3;
  } op_t;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_CLR, S_RD, S_LD, S_EXEC, S_WB} state_t;

  cmd_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  state_t        state_q, state_d;
  op_t           cmd_q, cmd_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          tmo_flag_q, tmo_flag_d;
  logic [4:0]    addr1_q, addr1_d, addr2_q, addr2_d, addr3_q, addr3_d;
  logic [2:0]    opcode_q, opcode_d, round_q, round_d;
  logic          enable_q, enable_d, ld_q, ld_d, act_q, act_d;
  logic [31:0]   inp_q, inp_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q, res_data_d;
  logic [8:0]    res_flags_q, res_flags_d;

  logic fifo_empty, fifo_full, pop, push, wb_fire;
  cmd_t cmd_in, head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (AW+1)'(DEPTH));
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign bus.cmd_ready = !fifo_full || pop;
  assign push       = bus.cmd_valid && bus.cmd_ready;
  assign cmd_in     = {bus.cmd_op, bus.cmd_rm, bus.cmd_a1, bus.cmd_a2, bus.cmd_a3, bus.cmd_data};
  assign head       = fifo_mem[rd_ptr_q];
  assign wb_fire    = (state_q == S_WB) && (!res_valid_q || bus.res_ready);

  // Command storage; payload only, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_in;
  end

  // Next-state, FIFO pointer and registered fpu/result output computation.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d       = cnt_q;
    if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
    if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    state_d     = state_q;
    cmd_d       = cmd_q;
    tmo_d       = tmo_q;
    tmo_flag_d  = tmo_flag_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    addr3_d     = addr3_q;
    opcode_d    = opcode_q;
    round_d     = round_q;
    enable_d    = enable_q;
    ld_d        = ld_q;
    act_d       = act_q;
    inp_d       = inp_q;
    res_valid_d = res_valid_q && !bus.res_ready;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cmd_d = {head.op, head.rm, head.a1, head.a2, head.a3};
          if (head.op == 3'd7) begin
            state_d  = S_WR;
            enable_d = 1'b0;
            addr1_d  = head.a1;
            inp_d    = head.data;
          end else if (head.op != 3'd5 && head.op != 3'd6) begin
            // Writing 0 to the scratch word restarts the fpu done counter.
            state_d  = S_CLR;
            enable_d = 1'b0;
            addr1_d  = 5'(SCR_ADDR);
            inp_d    = 32'd0;
          end
        end
      end
      S_WR: begin
        state_d  = S_IDLE;
        enable_d = 1'b1;
      end
      S_CLR: begin
        state_d  = S_RD;
        enable_d = 1'b1;
        ld_d     = 1'b0;
        addr1_d  = cmd_q.a1;
        addr2_d  = cmd_q.a2;
        addr3_d  = cmd_q.a3;
        opcode_d = cmd_q.op;
        round_d  = cmd_q.rm;
      end
      S_RD: begin
        state_d = S_LD;
        ld_d    = 1'b1;
      end
      S_LD: begin
        state_d = S_EXEC;
        ld_d    = 1'b0;
        act_d   = 1'b1;
        tmo_d   = 8'd0;
      end
      S_EXEC: begin
        if (bus.fpu_done) begin
          state_d    = S_WB;
          tmo_flag_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == 8'(TIMEOUT)) begin
            state_d    = S_WB;
            tmo_flag_d = 1'b1;
          end
        end
      end
      S_WB: begin
        // While the result slot is blocked the fpu keeps writing dest; that is idempotent.
        if (wb_fire) begin
          res_valid_d = 1'b1;
          res_data_d  = tmo_flag_q ? 32'd0 : bus.fpu_out;
          res_flags_d = {tmo_flag_q, tmo_flag_q ? 8'h00 : bus.fpu_flags};
          state_d     = S_IDLE;
          enable_d    = 1'b1;
          ld_d        = 1'b0;
          act_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All sequencer state; reset discards any in-flight op and empties the FIFO.
  always_ff @(posedge clk or negedge rstp) begin
    if (!rstp) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      tmo_q       <= '0;
      tmo_flag_q  <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      addr3_q     <= '0;
      opcode_q    <= '0;
      round_q     <= '0;
      enable_q    <= 1'b1;
      ld_q        <= 1'b0;
      act_q       <= 1'b0;
      inp_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      tmo_q       <= tmo_d;
      tmo_flag_q  <= tmo_flag_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      addr3_q     <= addr3_d;
      opcode_q    <= opcode_d;
      round_q     <= round_d;
      enable_q    <= enable_d;
      ld_q        <= ld_d;
      act_q       <= act_d;
      inp_q       <= inp_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
    end
  end

  assign bus.fpu_addr1  = addr1_q;
  assign bus.fpu_addr2  = addr2_q;
  assign bus.fpu_addr3  = addr3_q;
  assign bus.fpu_opcode = opcode_q;
  assign bus.fpu_round  = round_q;
  assign bus.fpu_enable = enable_q;
  assign bus.fpu_ld     = ld_q;
  assign bus.fpu_act    = act_q;
  assign bus.fpu_inp    = inp_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_flags  = res_flags_q;
  assign bus.busy       = (state_q != S_IDLE) || !fifo_empty;

`ifdef FPU_SEQ_PERF_EN
  logic [15:0] perf_ops_q, perf_ops_d, perf_tmo_q, perf_tmo_d;

  // Saturating counts of completed and timed-out ops, bumped on WB exit.
  always_comb begin
    perf_ops_d = perf_ops_q;
    perf_tmo_d = perf_tmo_q;
    if (wb_fire && !tmo_flag_q && perf_ops_q != 16'hFFFF) perf_ops_d = perf_ops_q + 16'd1;
    if (wb_fire &&  tmo_flag_q && perf_tmo_q != 16'hFFFF) perf_tmo_d = perf_tmo_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstp) begin
    if (!rstp) begin
      perf_ops_q <= '0;
      perf_tmo_q <= '0;
    end else begin
      perf_ops_q <= perf_ops_d;
      perf_tmo_q <= perf_tmo_d;
    end
  end

  assign bus.perf_ops = perf_ops_q;
  assign bus.perf_tmo = perf_tmo_q;
`else
  assign bus.perf_ops = 16'd0;
  assign bus.perf_tmo = 16'd0;
`endif
endmodule

// File: tb/tb_fpu_cmd_seq.sv
// tb_fpu_cmd_seq: directed bench for fpu_cmd_seq with a behavioural fpu and a result scoreboard.
// Latency: checks cmd-to-result latency and the EXEC timeout length.
// Backpressure: exercises res_ready stalls and a full command FIFO.
module tb_fpu_cmd_seq;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstp;
  always #5 clk = ~clk;

  fpu_cmd_seq_if bus ();

  fpu_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT(15), .SCR_ADDR(31)) dut (
    .clk  (clk),
    .rstp (rstp),
    .bus  (bus)
  );

  typedef struct packed {
    logic [8:0]  f;
    logic [31:0] d;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   t_acc = 0;
  int   n_ok  = 0;
  res_t exp_q [$];
  res_t mon_e;
  logic [31:0] smem [32] = '{default: 32'd0};

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural fpu: stands in for real float arithmetic on the operand pairs used here.
  function automatic logic [39:0] fmodel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r = 32'd0;
    logic [7:0]  f = 8'h00;
    case (op)
      3'd0: r = (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
      3'd1: r = (a == 32'h40000000 && b == 32'h40400000) ? 32'h40C00000 : a ^ b;
      3'd2: if (b == 32'd0) begin r = 32'h7F800000; f = 8'h08; end else r = a - b;
      3'd3: r = ~a;
      3'd4: f = {5'b0, a == b, a < b, a > b};
      default: r = 32'd0;
    endcase
    return {f, r};
  endfunction

  logic [31:0] fmem [32] = '{default: 32'd0};
  logic [31:0] opa = 32'd0, opb = 32'd0, out_r = 32'd0;
  logic [7:0]  flg_r = 8'h00;
  logic        done_r = 1'b0;
  logic        fpu_dead = 1'b0;

  always @(posedge clk) begin
    if (!bus.fpu_enable) begin
      fmem[bus.fpu_addr1] <= bus.fpu_inp;
      if (bus.fpu_addr1 == 5'd31 && bus.fpu_inp == 32'd0) done_r <= 1'b0;
    end
    if (bus.fpu_ld) begin
      opa <= fmem[bus.fpu_addr1];
      opb <= fmem[bus.fpu_addr2];
    end
    if (bus.fpu_act && !done_r) begin
      {flg_r, out_r} <= fmodel(bus.fpu_opcode, opa, opb);
      done_r <= 1'b1;
    end
    if (bus.fpu_enable && bus.fpu_act && done_r) fmem[bus.fpu_addr3] <= out_r;
  end
  assign bus.fpu_done  = done_r && !fpu_dead;
  assign bus.fpu_out   = out_r;
  assign bus.fpu_flags = flg_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 no result expected, 1 normal result, 2 timeout result
  task automatic push_cmd(input logic [2:0] op, input logic [2:0] rm, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3, input logic [31:0] data,
                          input int mode);
    int w = 0;
    logic [39:0] fm;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rm    = rm;
    bus.cmd_a1    = a1;
    bus.cmd_a2    = a2;
    bus.cmd_a3    = a3;
    bus.cmd_data  = data;
    while (!bus.cmd_ready && w < 200) begin step(); w++; end
    check("cmd_accept", 64'(bus.cmd_ready), 64'd1);
    step();
    t_acc = cyc;
    bus.cmd_valid = 1'b0;
    fm = fmodel(op, smem[a1], smem[a2]);
    if (op == 3'd7) smem[a1] = data;
    if (mode == 1) begin
      exp_q.push_back({1'b0, fm});
      smem[a3] = fm[31:0];
      n_ok++;
    end else if (mode == 2) begin
      exp_q.push_back({9'h100, 32'd0});
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((bus.busy || bus.res_valid) && w < 400) begin step(); w++; end
    check("idle_bound", 64'(!bus.busy && !bus.res_valid), 64'd1);
  endtask

  task automatic wait_res();
    int w = 0;
    while (!bus.res_valid && w < 100) begin step(); w++; end
    check("res_bound", 64'(bus.res_valid), 64'd1);
  endtask

  task automatic chk_reset(input string p);
    check({p, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    check({p, "_busy"},      64'(bus.busy), 64'd0);
    check({p, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    check({p, "_res"},       64'({bus.res_flags, bus.res_data}), 64'd0);
    check({p, "_pins"},      64'({bus.fpu_enable, bus.fpu_ld, bus.fpu_act}), 64'b100);
    check({p, "_addr"},      64'({bus.fpu_addr1, bus.fpu_addr2, bus.fpu_addr3,
                                  bus.fpu_opcode, bus.fpu_round}), 64'd0);
    check({p, "_inp"},       64'(bus.fpu_inp), 64'd0);
    check({p, "_perf"},      64'({bus.perf_ops, bus.perf_tmo}), 64'd0);
  endtask

  // Scoreboard: compare every accepted result with the oldest expectation.
  always @(negedge clk) begin
    if (bus.res_valid && bus.res_ready) begin
      check("res_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("res_data",  64'(bus.res_data),  64'(mon_e.d));
        check("res_flags", 64'(bus.res_flags), 64'(mon_e.f));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tl;
    rstp          = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_rm    = 3'd0;
    bus.cmd_a1    = 5'd0;
    bus.cmd_a2    = 5'd0;
    bus.cmd_a3    = 5'd0;
    bus.cmd_data  = 32'd0;
    bus.res_ready = 1'b1;
    repeat (3) step();
    chk_reset("rst");
    rstp = 1'b1;
    step();

    // Host writes then 1.0 + 2.0, with latency measured from an empty FIFO.
    push_cmd(3'd7, 3'd0, 5'd3, 5'd0, 5'd0, 32'h3F800000, 0);
    push_cmd(3'd7, 3'd0, 5'd4, 5'd0, 5'd0, 32'h40000000, 0);
    wait_idle();
    check("host_wr3", 64'(fmem[3]), 64'h3F800000);
    check("host_wr4", 64'(fmem[4]), 64'h40000000);
    push_cmd(3'd0, 3'd0, 5'd3, 5'd4, 5'd5, 32'd0, 1);
    tl = t_acc;
    wait_res();
    check("lat_add", 64'(cyc - tl), 64'd7);
    wait_idle();
    check("mem5", 64'(fmem[5]), 64'h40400000);

    // 2.0 * 3.0 with the result held for 10 cycles.
    bus.res_ready = 1'b0;
    push_cmd(3'd1, 3'd2, 5'd4, 5'd5, 5'd6, 32'd0, 1);
    wait_res();
    for (int i = 0; i < 10; i++) begin
      check("stall_res", 64'({bus.res_valid, bus.res_data}), {31'd0, 1'b1, 32'h40C00000});
      check("stall_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      step();
    end

    // DEPTH+1 back-to-back pushes while the result slot is blocked; op 5 is dropped.
    push_cmd(3'd0, 3'd0, 5'd3, 5'd5, 5'd20, 32'd0, 1);
    push_cmd(3'd4, 3'd0, 5'd3, 5'd4, 5'd21, 32'd0, 1);
    push_cmd(3'd5, 3'd0, 5'd1, 5'd1, 5'd1,  32'd0, 0);
    push_cmd(3'd3, 3'd1, 5'd4, 5'd0, 5'd22, 32'd0, 1);
    push_cmd(3'd2, 3'd0, 5'd5, 5'd4, 5'd23, 32'd0, 1);
    repeat (12) step();
    check("full_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("wb_hold_pins", 64'({bus.fpu_enable, bus.fpu_act, bus.busy}), 64'b111);
    check("wb_hold_res", 64'(bus.res_data), 64'h40C00000);
    bus.res_ready = 1'b1;
    wait_idle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // 1.0 / 0.0
    push_cmd(3'd2, 3'd0, 5'd3, 5'd0, 5'd8, 32'd0, 1);
    wait_idle();
    check("mem8", 64'(fmem[8]), 64'h7F800000);

    // Missing done: abort after TIMEOUT EXEC cycles.
    fpu_dead = 1'b1;
    push_cmd(3'd0, 3'd0, 5'd3, 5'd4, 5'd24, 32'd0, 2);
    begin
      int w = 0;
      while (!bus.fpu_ld && w < 50) begin step(); w++; end
      check("ld_bound", 64'(bus.fpu_ld), 64'd1);
    end
    tl = cyc;
    wait_res();
    check("tmo_lat", 64'(cyc - tl), 64'd17);
    wait_idle();
    fpu_dead = 1'b0;
`ifdef FPU_SEQ_PERF_EN
    check("perf_tmo", 64'(bus.perf_tmo), 64'd1);
    check("perf_ops", 64'(bus.perf_ops), 64'(n_ok));
`else
    check("perf_tied", 64'({bus.perf_ops, bus.perf_tmo}), 64'd0);
`endif

    // Reset while in EXEC, then a normal op.
    push_cmd(3'd0, 3'd0, 5'd3, 5'd4, 5'd25, 32'd0, 0);
    begin
      int w = 0;
      while (!bus.fpu_act && w < 50) begin step(); w++; end
      check("act_bound", 64'(bus.fpu_act), 64'd1);
    end
    rstp = 1'b0;
    #1;
    chk_reset("arst");
    step();
    chk_reset("arst_edge");
    rstp = 1'b1;
    step();
    push_cmd(3'd0, 3'd0, 5'd3, 5'd4, 5'd26, 32'd0, 1);
    wait_idle();
    check("post_rst_mem", 64'(fmem[26]), 64'h40400000);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
